// File: rtl/f_btb_fetch_pkg.sv
// Shared definitions for the fetch-side BTB reader. The entry layout here must stay
// in step with the E-stage writer that packs w_data.
package f_btb_fetch_pkg;

    localparam int PC_W  = 13;
    localparam int TAG_W = 2;
    localparam int IDX_W = PC_W - TAG_W;
    localparam int ENT_W = 16;
    localparam int DEPTH = 1 << IDX_W;

    localparam int VALID_BIT = 15;
    localparam int TAG_MSB   = 14;
    localparam int TAG_LSB   = 13;
    localparam int TGT_MSB   = 12;
    localparam int TGT_LSB   = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Same packing the E-stage uses: {valid, source tag, jump target}
    function automatic logic [ENT_W-1:0] pack_entry(input logic [PC_W-1:0] src_pc,
                                                    input logic [PC_W-1:0] tgt);
        return {1'b1, src_pc[PC_W-1 -: TAG_W], tgt};
    endfunction

endpackage

// File: rtl/f_btb_fetch_btb_ram.sv
// BTB storage: one asynchronous read port for the fetch lookup, one synchronous
// write port shared by the clear sweep and the E-stage writer. Contents are not reset.
module f_btb_fetch_btb_ram
    import f_btb_fetch_pkg::*;
(
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr,
    output logic [ENT_W-1:0] rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [ENT_W-1:0] wdata
);

    logic [ENT_W-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/f_btb_fetch.sv
// Fetch PC register with zero-latency BTB prediction; a clear FSM sweeps the table
// after reset and on flush, during which fetch keeps running sequentially.
module f_btb_fetch
    import f_btb_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             flush,
    input  logic [ENT_W-1:0] w_data,
    input  logic [IDX_W-1:0] w_addr,
    input  logic             wen,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_predicted,
    output logic             btb_hit,
    output logic             busy,
    output logic [31:0]      hit_count
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sweep_idx;
    logic             idle;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [ENT_W-1:0] ram_wdata;
    logic [ENT_W-1:0] ram_rdata;
    logic [ENT_W-1:0] entry;
    logic             bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    // flush wins over the end-of-sweep exit so a late flush still restarts the sweep
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (!flush && sweep_idx == IDX_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  if (flush) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        idle      = 1'b0;
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = sweep_idx;
        ram_wdata = '0;
        if (state == ST_IDLE) begin
            idle      = 1'b1;
            busy      = 1'b0;
            ram_we    = wen;
            ram_waddr = w_addr;
            ram_wdata = w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  sweep_idx <= '0;
        else if (flush)              sweep_idx <= '0;
        else if (state == ST_CLEAR)  sweep_idx <= sweep_idx + IDX_W'(1);
    end

    f_btb_fetch_btb_ram u_btb_ram (
        .clk   (clk),
        .raddr (pc[IDX_W-1:0]),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    // An E-stage write to the slot being looked up is visible in the same cycle
    assign bypass = idle && wen && (w_addr == pc[IDX_W-1:0]);
    assign entry  = bypass ? w_data : ram_rdata;

    assign btb_hit      = idle && entry[VALID_BIT] &&
                          (entry[TAG_MSB:TAG_LSB] == pc[PC_W-1:IDX_W]);
    assign pc_predicted = btb_hit ? entry[TGT_MSB:TGT_LSB] : pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pc <= '0;
        else if (redirect)  pc <= redirect_pc;
        else if (!stall)    pc <= pc_predicted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_count <= '0;
        else if (btb_hit && !stall && !redirect && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
    end

endmodule

// File: tb/tb_f_btb_fetch.sv
// Directed bench for f_btb_fetch: a reference model predicts every cycle, expected
// pc/hit_count go through a scoreboard queue and are checked after the clock edge.
module tb_f_btb_fetch;
    import f_btb_fetch_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, redirect, flush, wen;
    logic [PC_W-1:0]  redirect_pc;
    logic [ENT_W-1:0] w_data;
    logic [IDX_W-1:0] w_addr;
    logic [PC_W-1:0]  pc, pc_predicted;
    logic             btb_hit, busy;
    logic [31:0]      hit_count;

    f_btb_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .w_data       (w_data),
        .w_addr       (w_addr),
        .wen          (wen),
        .pc           (pc),
        .pc_predicted (pc_predicted),
        .btb_hit      (btb_hit),
        .busy         (busy),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     hits;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [PC_W-1:0]  m_pc;
    logic [31:0]      m_hits;
    int               m_clear;
    logic [ENT_W-1:0] m_tab [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_hits  = '0;
        m_clear = DEPTH;
        m_tab.delete();
        sb.delete();
    endtask

    // One clock: check combinational outputs, push expected post-edge state, compare after edge
    task automatic cycle();
        logic [ENT_W-1:0] e;
        logic             hit;
        logic [PC_W-1:0]  pred, nxt;
        exp_t             x;
        int               idx;
        #1;
        idx  = int'(m_pc[IDX_W-1:0]);
        e    = (m_clear == 0 && m_tab.exists(idx)) ? m_tab[idx] : '0;
        if (m_clear == 0 && wen && w_addr == m_pc[IDX_W-1:0]) e = w_data;
        hit  = (m_clear == 0) && e[15] && (e[14:13] == m_pc[12:11]);
        pred = hit ? e[12:0] : m_pc + 13'd1;
        check("busy", 32'(busy), 32'(m_clear != 0));
        check("btb_hit", 32'(btb_hit), 32'(hit));
        check("pc_predicted", 32'(pc_predicted), 32'(pred));
        nxt = redirect ? redirect_pc : (!stall ? pred : m_pc);
        if (hit && !stall && !redirect && m_hits != 32'hFFFF_FFFF) m_hits++;
        if (m_clear == 0 && wen) m_tab[int'(w_addr)] = w_data;
        if (flush) begin
            m_clear = DEPTH;
            m_tab.delete();
        end else if (m_clear != 0) begin
            m_clear--;
        end
        m_pc   = nxt;
        x.pc   = nxt;
        x.hits = m_hits;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            check("pc", 32'(pc), 32'(x.pc));
            check("hit_count", hit_count, x.hits);
        end
    endtask

    task automatic redir(input logic [PC_W-1:0] p);
        redirect    = 1'b1;
        redirect_pc = p;
        cycle();
        redirect    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [31:0] saved_hits;

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; flush = 1'b0; wen = 1'b0;
        redirect_pc = '0; w_data = '0; w_addr = '0;
        model_reset();
        #12;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);
        check("reset_hit_count", hit_count, 32'h0);
        rst_n = 1'b1;

        // Initial sweep: sequential fetch, busy for exactly 2048 cycles
        cycle();
        check("pc_seq1", 32'(pc), 32'h1);
        cycle();
        check("pc_seq2", 32'(pc), 32'h2);
        run(2045);
        check("busy_last_sweep", 32'(busy), 32'h1);
        cycle();
        check("busy_after_sweep", 32'(busy), 32'h0);

        // Populate 0x010 -> 0x0400
        wen = 1'b1; w_addr = 11'h010; w_data = 16'h8400;
        check("pack_entry", 32'(pack_entry(13'h0010, 13'h0400)), 32'h8400);
        cycle();
        wen = 1'b0;
        redir(13'h000E);
        run(2);
        check("hit_at_010", 32'(btb_hit), 32'h1);
        check("pred_at_010", 32'(pc_predicted), 32'h0400);
        cycle();
        check("pc_after_hit", 32'(pc), 32'h0400);

        // Same index, different tag
        redir(13'h0810);
        check("tagmiss_hit", 32'(btb_hit), 32'h0);
        check("tagmiss_pred", 32'(pc_predicted), 32'h0811);
        cycle();

        // Same-cycle write bypass
        redir(13'h0020);
        wen = 1'b1; w_addr = 11'h020; w_data = 16'h8100;
        #1;
        check("bypass_pred", 32'(pc_predicted), 32'h0100);
        cycle();
        wen = 1'b0;
        check("bypass_next_pc", 32'(pc), 32'h0100);

        // redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 13'h0123;
        cycle();
        stall = 1'b0; redirect = 1'b0;
        check("redirect_over_stall", 32'(pc), 32'h0123);

        // stall on a hitting pc: hold pc, no count
        redir(13'h0010);
        saved_hits = m_hits;
        stall = 1'b1;
        cycle();
        stall = 1'b0;
        check("stall_hold_pc", 32'(pc), 32'h0010);
        check("stall_no_count", hit_count, saved_hits);
        cycle();
        check("hit_counted", hit_count, saved_hits + 32'd1);

        // Wrap-around on miss
        redir(13'h1FFF);
        check("wrap_miss", 32'(btb_hit), 32'h0);
        cycle();
        check("wrap_pc", 32'(pc), 32'h0000);

        // Flush, then re-flush mid-sweep to restart it
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'h1);
        run(100);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run(2047);
        check("reflush_still_busy", 32'(busy), 32'h1);
        cycle();
        check("reflush_done", 32'(busy), 32'h0);
        redir(13'h0010);
        check("flushed_miss", 32'(btb_hit), 32'h0);
        check("flushed_pred", 32'(pc_predicted), 32'h0011);
        cycle();

        // Reset in the middle of a sweep restarts everything
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run(10);
        rst_n = 1'b0;
        #2;
        check("midreset_pc", 32'(pc), 32'h0);
        check("midreset_busy", 32'(busy), 32'h1);
        check("midreset_hits", hit_count, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(2048);
        check("midreset_sweep_done", 32'(busy), 32'h0);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
